bus_initiator: RTL

//  Single-master initiator for the shared SoC bus; the issuing end of the protocol that memory/print slaves answer.

---
 rtl/bus_if_pkg.sv | 17 +
 rtl/bus_initiator_if.sv | 52 +++++
 rtl/bus_initiator.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/bus_if_pkg.sv
// Shared widths and the controller state type for the SoC bus initiator.
package bus_if_pkg;

  localparam int BUS_BURST_W = 8;
  localparam int BUS_DATA_W  = 32;
  localparam int BUS_BE_W    = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_BEGIN = 3'd2,
    ST_WRITE = 3'd3,
    ST_WEND  = 3'd4,
    ST_READ  = 3'd5
  } state_t;

endpackage

// File: rtl/bus_initiator_if.sv
// Local command/stream side plus shared-bus side of the initiator, bundled for port connection.
interface bus_initiator_if;
  import bus_if_pkg::*;

  logic                   cmd_valid_i;
  logic                   cmd_ready_o;
  logic [BUS_DATA_W-1:0]  cmd_addr_i;
  logic                   cmd_rnw_i;
  logic [BUS_BURST_W-1:0] cmd_burst_i;
  logic [BUS_BE_W-1:0]    cmd_be_i;
  logic                   wdata_valid_i;
  logic                   wdata_ready_o;
  logic [BUS_DATA_W-1:0]  wdata_i;
  logic                   rdata_valid_o;
  logic [BUS_DATA_W-1:0]  rdata_o;
  logic                   rdata_last_o;
  logic                   done_o;
  logic                   error_o;
  logic                   request_o;
  logic                   grant_i;
  logic                   beginTransaction_o;
  logic                   endTransaction_o;
  logic [BUS_DATA_W-1:0]  addressData_o;
  logic [BUS_BE_W-1:0]    byteEnables_o;
  logic                   readNotWrite_o;
  logic [BUS_BURST_W-1:0] burstSize_o;
  logic                   dataValid_o;
  logic                   endTransaction_i;
  logic                   dataValid_i;
  logic [BUS_DATA_W-1:0]  addressData_i;
  logic                   busy_i;
  logic                   busError_i;

  modport master (
    input  cmd_valid_i, cmd_addr_i, cmd_rnw_i, cmd_burst_i, cmd_be_i,
    input  wdata_valid_i, wdata_i, grant_i, endTransaction_i, dataValid_i,
    input  addressData_i, busy_i, busError_i,
    output cmd_ready_o, wdata_ready_o, rdata_valid_o, rdata_o, rdata_last_o,
    output done_o, error_o, request_o, beginTransaction_o, endTransaction_o,
    output addressData_o, byteEnables_o, readNotWrite_o, burstSize_o, dataValid_o
  );

  modport slave (
    output cmd_valid_i, cmd_addr_i, cmd_rnw_i, cmd_burst_i, cmd_be_i,
    output wdata_valid_i, wdata_i, grant_i, endTransaction_i, dataValid_i,
    output addressData_i, busy_i, busError_i,
    input  cmd_ready_o, wdata_ready_o, rdata_valid_o, rdata_o, rdata_last_o,
    input  done_o, error_o, request_o, beginTransaction_o, endTransaction_o,
    input  addressData_o, byteEnables_o, readNotWrite_o, burstSize_o, dataValid_o
  );

endinterface

// File: rtl/bus_initiator.sv
// Single-master bus initiator: arbitrates, issues one BEGIN, then streams write beats or collects read beats.
// Bus drives are decoded from the state register, so they vanish with reset or on the return to IDLE.
module bus_initiator
  import bus_if_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  bus_initiator_if.master bus
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  // Abort lands on the silent cycle that makes error_o appear TIMEOUT_CYCLES after BEGIN.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 2);

  state_t                 state_q, state_d;
  logic [BUS_DATA_W-1:0]  addr_q, addr_d;
  logic                   rnw_q, rnw_d;
  logic [BUS_BURST_W-1:0] burst_q, burst_d;
  logic [BUS_BURST_W-1:0] cnt_q, cnt_d;
  logic [BUS_BE_W-1:0]    be_q, be_d;
  logic                   all_rx_q, all_rx_d;
  logic                   mism_q, mism_d;
  logic [TMO_W-1:0]       tmo_q, tmo_d;
  logic                   ready_q, ready_d;
  logic                   done_q, done_d;
  logic                   error_q, error_d;
  logic                   rvalid_q, rvalid_d;
  logic                   rlast_q, rlast_d;
  logic [BUS_DATA_W-1:0]  rdata_q, rdata_d;

  logic in_begin_s, in_write_s, in_read_s, active_s, timed_s;
  logic wvalid_s, retire_s, rx_beat_s, expired_s, abort_s;
  logic complete_s, mismatch_s;

  assign in_begin_s = (state_q == ST_BEGIN);
  assign in_write_s = (state_q == ST_WRITE);
  assign in_read_s  = (state_q == ST_READ);
  assign timed_s    = in_write_s | in_read_s;
  assign active_s   = in_begin_s | timed_s | (state_q == ST_WEND);
  assign wvalid_s   = in_write_s & bus.wdata_valid_i;
  assign retire_s   = wvalid_s & ~bus.busy_i;
  assign rx_beat_s  = in_read_s & bus.dataValid_i;
  assign expired_s  = timed_s & ~retire_s & ~rx_beat_s & (tmo_q == TMO_LAST);
  assign abort_s    = active_s & (bus.busError_i | expired_s);

  // Next-state, command latch, beat accounting and completion pulses.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rnw_d      = rnw_q;
    burst_d    = burst_q;
    be_d       = be_q;
    cnt_d      = cnt_q;
    all_rx_d   = all_rx_q;
    mism_d     = mism_q;
    tmo_d      = tmo_q;
    done_d     = 1'b0;
    error_d    = 1'b0;
    rvalid_d   = 1'b0;
    rlast_d    = 1'b0;
    rdata_d    = rdata_q;
    complete_s = 1'b0;
    mismatch_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tmo_d = {TMO_W{1'b0}};
        if (bus.cmd_valid_i) begin
          addr_d   = bus.cmd_addr_i;
          rnw_d    = bus.cmd_rnw_i;
          burst_d  = bus.cmd_burst_i;
          be_d     = bus.cmd_be_i;
          cnt_d    = bus.cmd_burst_i;
          all_rx_d = 1'b0;
          mism_d   = 1'b0;
          state_d  = ST_REQ;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (bus.grant_i) begin
          state_d = ST_BEGIN;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_BEGIN: begin
        tmo_d   = {TMO_W{1'b0}};
        state_d = rnw_q ? ST_READ : ST_WRITE;
      end
      ST_WRITE: begin
        if (retire_s) begin
          tmo_d = {TMO_W{1'b0}};
          if (cnt_q == 8'd0) begin
            state_d = ST_WEND;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end else begin
          tmo_d = tmo_q + {{(TMO_W-1){1'b0}}, 1'b1};
        end
      end
      ST_WEND: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      ST_READ: begin
        // Beats beyond the expected count are dropped but poison the completion.
        if (rx_beat_s) begin
          tmo_d = {TMO_W{1'b0}};
          if (all_rx_q) begin
            mism_d = 1'b1;
          end else begin
            rvalid_d = 1'b1;
            rdata_d  = bus.addressData_i;
            rlast_d  = (cnt_q == 8'd0);
            if (cnt_q == 8'd0) begin
              all_rx_d = 1'b1;
            end else begin
              cnt_d = cnt_q - 8'd1;
            end
          end
        end else begin
          tmo_d = tmo_q + {{(TMO_W-1){1'b0}}, 1'b1};
        end
        if (bus.endTransaction_i) begin
          complete_s = all_rx_q | (rx_beat_s & (cnt_q == 8'd0));
          mismatch_s = mism_q | (rx_beat_s & all_rx_q);
          done_d     = complete_s & ~mismatch_s;
          error_d    = ~(complete_s & ~mismatch_s);
          state_d    = ST_IDLE;
        end else begin
          state_d    = ST_READ;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (abort_s) begin
      state_d  = ST_IDLE;
      done_d   = 1'b0;
      error_d  = 1'b1;
      rvalid_d = 1'b0;
      rlast_d  = 1'b0;
    end else begin
      error_d  = error_d;
    end
    ready_d = (state_d == ST_IDLE);
  end

  // State and output registers; reset discards any latched command.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      addr_q   <= 32'd0;
      rnw_q    <= 1'b0;
      burst_q  <= 8'd0;
      be_q     <= 4'd0;
      cnt_q    <= 8'd0;
      all_rx_q <= 1'b0;
      mism_q   <= 1'b0;
      tmo_q    <= {TMO_W{1'b0}};
      ready_q  <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
      rdata_q  <= 32'd0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rnw_q    <= rnw_d;
      burst_q  <= burst_d;
      be_q     <= be_d;
      cnt_q    <= cnt_d;
      all_rx_q <= all_rx_d;
      mism_q   <= mism_d;
      tmo_q    <= tmo_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      error_q  <= error_d;
      rvalid_q <= rvalid_d;
      rlast_q  <= rlast_d;
      rdata_q  <= rdata_d;
    end
  end

  assign bus.cmd_ready_o        = ready_q;
  assign bus.request_o          = (state_q != ST_IDLE);
  assign bus.beginTransaction_o = in_begin_s;
  assign bus.addressData_o      = in_begin_s ? addr_q : (wvalid_s ? bus.wdata_i : 32'd0);
  assign bus.byteEnables_o      = in_begin_s ? be_q : 4'd0;
  assign bus.readNotWrite_o     = in_begin_s & rnw_q;
  assign bus.burstSize_o        = in_begin_s ? burst_q : 8'd0;
  assign bus.dataValid_o        = wvalid_s;
  assign bus.wdata_ready_o      = retire_s;
  assign bus.endTransaction_o   = (state_q == ST_WEND) & ~bus.busError_i;
  assign bus.done_o             = done_q;
  assign bus.error_o            = error_q;
  assign bus.rdata_valid_o      = rvalid_q;
  assign bus.rdata_o            = rdata_q;
  assign bus.rdata_last_o       = rlast_q;

endmodule
